// File: rtl/bscan.sv
// Set-bit scanner: expands a W-bit word into one beat per set bit (ascending index).
// Latency: first beat the cycle after input acceptance; k beats per word (1 if zero).
// Backpressure: out_ready low holds the current beat; in_ready only on idle or last-beat retire.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data[W] (+ in_dir with
// BSCAN_REV_EN) accept a word; out_valid/out_ready/out_index[ORDER]/out_last/out_empty
// emit one set-bit position per beat.
// Optional feature macro: BSCAN_REV_EN enables per-word MSB-first scanning via in_dir.
module bscan #(
    parameter int ORDER = 3,
    parameter int W     = 2 ** ORDER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
`ifdef BSCAN_REV_EN
    input  logic             in_dir,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ORDER-1:0] out_index,
    output logic             out_last,
    output logic             out_empty
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, SCAN} state_t;

    state_t       state, state_nx;
    logic [W-1:0] word, word_nx;
    logic         empty, empty_nx;
    logic         in_hs, out_hs;
    logic [W-1:0] bit_sel;

    // Lowest set bit; a zero word reports index 0 (covers the empty beat).
    function automatic logic [ORDER-1:0] lsb_idx(input logic [W-1:0] v);
        lsb_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) lsb_idx = i[ORDER-1:0];
        end
    endfunction

`ifdef BSCAN_REV_EN
    logic dir, dir_nx;

    // Highest set bit, i.e. W-1-clz(v).
    function automatic logic [ORDER-1:0] msb_idx(input logic [W-1:0] v);
        msb_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) msb_idx = i[ORDER-1:0];
        end
    endfunction

    assign out_index = dir ? msb_idx(word) : lsb_idx(word);
`else
    assign out_index = lsb_idx(word);
`endif

    // Output beat is purely a function of registered state.
    assign out_valid = (state == SCAN);
    assign out_last  = (state == SCAN) && ((word & (word - ONE)) == '0);
    assign out_empty = (state == SCAN) && empty;

    // Pass-through lets the next word load on the edge that retires the last beat.
    assign in_ready = (state == IDLE) || (out_ready && out_last);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    always_comb begin
        bit_sel            = '0;
        bit_sel[out_index] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        word_nx  = word;
        empty_nx = empty;
`ifdef BSCAN_REV_EN
        dir_nx   = dir;
`endif
        case (state)
            IDLE: begin
                if (in_hs) begin
                    state_nx = SCAN;
                    word_nx  = in_data;
                    empty_nx = (in_data == '0);
`ifdef BSCAN_REV_EN
                    dir_nx   = in_dir;
`endif
                end
            end
            SCAN: begin
                if (out_hs) begin
                    if (!out_last) begin
                        word_nx = word & ~bit_sel;
                    end else if (in_hs) begin
                        word_nx  = in_data;
                        empty_nx = (in_data == '0);
`ifdef BSCAN_REV_EN
                        dir_nx   = in_dir;
`endif
                    end else begin
                        state_nx = IDLE;
                        word_nx  = '0;
                        empty_nx = 1'b0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                word_nx  = '0;
                empty_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            word  <= '0;
            empty <= 1'b0;
`ifdef BSCAN_REV_EN
            dir   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            word  <= word_nx;
            empty <= empty_nx;
`ifdef BSCAN_REV_EN
            dir   <= dir_nx;
`endif
        end
    end

endmodule

// File: tb/tb_bscan.sv
// Bench for bscan (ORDER=3): per-word beat-list model plus directed literal checks.
module tb_bscan;

    localparam int ORDER = 3;
    localparam int W     = 8;

    typedef struct {
        int idx;
        int last;
        int empty;
        int cyc;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
`ifdef BSCAN_REV_EN
    logic             in_dir = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ORDER-1:0] out_index;
    logic             out_last;
    logic             out_empty;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit run_cmp = 1'b0;

    beat_t q[$];    // model: beats still owed for the word in flight
    beat_t obs[$];  // beats the DUT actually delivered

    bscan #(.ORDER(ORDER)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
`ifdef BSCAN_REV_EN
        .in_dir(in_dir),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_index(out_index),
        .out_last(out_last),
        .out_empty(out_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Word -> ordered list of set-bit positions; zero word is one empty beat.
    function automatic void expand(input logic [W-1:0] w, input bit msb_first);
        int pos[$];
        beat_t b;
        for (int i = 0; i < W; i++) if (w[i]) pos.push_back(i);
        if (msb_first) pos.reverse();
        if (pos.size() == 0) begin
            b.idx = 0; b.last = 1; b.empty = 1; b.cyc = 0;
            q.push_back(b);
        end else begin
            foreach (pos[k]) begin
                b.idx = pos[k]; b.last = (k == pos.size() - 1); b.empty = 0; b.cyc = 0;
                q.push_back(b);
            end
        end
    endfunction

    function automatic bit model_in_ready();
        return (q.size() == 0) || (out_ready && q.size() == 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            bit acc;
            bit dirv;
            cyc++;
            acc = in_valid && model_in_ready();
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            dirv = 1'b0;
`ifdef BSCAN_REV_EN
            dirv = in_dir;
`endif
            if (acc) expand(in_data, dirv);
        end
    end

    // Per-cycle comparison and beat capture, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && run_cmp) begin
            chk("in_ready", in_ready, model_in_ready());
            chk("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("out_index", out_index, q[0].idx);
                chk("out_last", out_last, q[0].last);
                chk("out_empty", out_empty, q[0].empty);
            end
        end
        if (rst_n && out_valid && out_ready) begin
            beat_t b;
            b.idx = out_index; b.last = out_last; b.empty = out_empty; b.cyc = cyc;
            obs.push_back(b);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] d, input bit dirv);
        in_valid = 1'b1;
        in_data  = d;
`ifdef BSCAN_REV_EN
        in_dir   = dirv;
`else
        if (dirv) $display("note: direction ignored without reverse scan");
`endif
        step();
        in_valid = 1'b0;
    endtask

    // Literal pin: indices in order, last only on the final beat, consecutive cycles.
    task automatic check_obs(input string nm, input int exp_idx[$], input int exp_empty);
        chk({nm, "_count"}, obs.size(), exp_idx.size());
        foreach (exp_idx[k]) begin
            if (k < obs.size()) begin
                chk({nm, "_idx"}, obs[k].idx, exp_idx[k]);
                chk({nm, "_last"}, obs[k].last, k == exp_idx.size() - 1);
                chk({nm, "_empty"}, obs[k].empty, exp_empty);
                chk({nm, "_gap"}, obs[k].cyc - obs[0].cyc, k);
            end
        end
        obs.delete();
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_empty", out_empty, 0);
        chk("rst_in_ready", in_ready, 1);
        #20 rst_n = 1'b1;
        step();
        run_cmp = 1'b1;

        // 0x96 LSB-first, free-running consumer
        out_ready = 1'b1;
        send(8'h96, 1'b0);
        step(5);
        check_obs("w96", '{1, 2, 4, 7}, 0);

        // Zero word: a single empty beat, then idle
        send(8'h00, 1'b0);
        step(2);
        check_obs("w00", '{0}, 1);
        chk("w00_idle", out_valid, 0);

        // 0x81 with consumer stalled for 3 cycles
        out_ready = 1'b0;
        send(8'h81, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("w81_hold_idx", out_index, 0);
            chk("w81_hold_vld", out_valid, 1);
            chk("w81_hold_rdy", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        step(3);
        check_obs("w81", '{0, 7}, 0);

        // Back-to-back 0x01 then 0x80: second loads on the first's last beat
        in_valid = 1'b1;
        in_data  = 8'h01;
        step();
        in_data  = 8'h80;
        @(negedge clk);
        chk("b2b_pass_rdy", in_ready, 1);
        step();
        in_valid = 1'b0;
        step(3);
        chk("b2b_count", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("b2b_idx0", obs[0].idx, 0);
            chk("b2b_last0", obs[0].last, 1);
            chk("b2b_idx1", obs[1].idx, 7);
            chk("b2b_last1", obs[1].last, 1);
            chk("b2b_gap", obs[1].cyc - obs[0].cyc, 1);
        end
        obs.delete();

`ifdef BSCAN_REV_EN
        send(8'h96, 1'b1);
        step(5);
        check_obs("rev96", '{7, 4, 2, 1}, 0);
        send(8'hFF, 1'b0);
        step(9);
        check_obs("fwdFF", '{0, 1, 2, 3, 4, 5, 6, 7}, 0);
`else
        send(8'hFF, 1'b0);
        step(9);
        check_obs("wFF", '{0, 1, 2, 3, 4, 5, 6, 7}, 0);
`endif

        // Mixed words with a randomly stalling consumer, checked by the model
        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] d;
            bit ok;
            d = (n % 6 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            in_valid = 1'b1;
            in_data  = d;
`ifdef BSCAN_REV_EN
            in_dir   = 1'($urandom_range(0, 1));
`endif
            ok = 1'b0;
            for (int t = 0; t < 60 && !ok; t++) begin
                out_ready = 1'($urandom_range(0, 3) != 0);
                @(negedge clk);
                ok = in_ready;
                step();
            end
            chk("sweep_accept_timeout", ok, 1);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        step(12);
        chk("sweep_drained", out_valid, 0);
        obs.delete();

        // Asynchronous reset mid-word after beat 2 of 0xFF
        send(8'hFF, 1'b0);
        step(3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_index", out_index, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_out_empty", out_empty, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_beats_before", obs.size(), 3);
        #14 rst_n = 1'b1;
        step(6);
        chk("arst_no_beats", obs.size(), 3);
        chk("arst_idle_vld", out_valid, 0);
        chk("arst_idle_rdy", in_ready, 1);
        obs.delete();

        // New word after reset still works
        send(8'h24, 1'b0);
        step(3);
        check_obs("post_rst", '{2, 5}, 0);

        run_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
